// File: rtl/reg_alu_seq_pkg.sv
// reg_alu_seq_pkg: control-word layout and sequencer state encodings
// Control word (CW_W bits): {sel, wr, op[1:0], rd_a[2:0], rd_b[2:0], wr_addr[2:0], d_in[15:0]}
package reg_alu_seq_pkg;

    localparam int CW_W    = 29;
    localparam int SEL_B   = 28;
    localparam int WR_B    = 27;
    localparam int OP_MSB  = 26;
    localparam int OP_LSB  = 25;
    localparam int RDA_MSB = 24;
    localparam int RDA_LSB = 22;
    localparam int RDB_MSB = 21;
    localparam int RDB_LSB = 19;
    localparam int WRA_MSB = 18;
    localparam int WRA_LSB = 16;
    localparam int DIN_MSB = 15;
    localparam int DIN_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/reg_alu_seq_if.sv
// reg_alu_seq_if: control port set of the reg_alu datapath
// Ports (signals):
//   sel, wr            1   select / register write enable
//   op                 2   ALU operation
//   rd_addr_a/b        3   read addresses
//   wr_addr            3   write address
//   d_in               16  immediate data
//   cout               1   carry returned by reg_alu
// master = sequencer (drives the control word), slave = reg_alu (returns cout)
interface reg_alu_seq_if;

    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        cout;

    modport master (
        output sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        input  cout
    );

    modport slave (
        input  sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output cout
    );

endinterface

// File: rtl/reg_alu_seq_prog_mem.sv
// seq_prog_mem: DEPTH x CW_W program store, synchronous write, asynchronous read
// Ports:
//   clk    in   clock
//   we     in   write enable (already gated by the sequencer)
//   waddr  in   PAW  write address
//   wdata  in   CW_W write data
//   raddr  in   PAW  read address
//   rdata  out  CW_W read data (combinational)
// Contents are intentionally not reset.
module seq_prog_mem
    import reg_alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PAW   = 3
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PAW-1:0]  waddr,
    input  logic [CW_W-1:0] wdata,
    input  logic [PAW-1:0]  raddr,
    output logic [CW_W-1:0] rdata
);

    logic [CW_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: control-word sequencer issuing one stored word per clock to reg_alu
// Ports:
//   clk, reset     in   clock, synchronous active-high reset
//   prog_we        in   program write (IDLE only)
//   prog_addr      in   PAW   program write address
//   prog_word      in   CW_W  program word
//   len            in   PAW+1 words to run, sampled with start (clamped to DEPTH)
//   start          in   begin run (IDLE only)
//   hold           in   bubble cycle, pc holds
//   abort          in   end run immediately, no done
//   alu            if   master side of the reg_alu control port (cout comes back)
//   busy           out  high in RUN and DRAIN
//   done           out  one-cycle pulse after a completed run
//   pc             out  PAW+1 index of next word to issue
//   carry_flag     out  sticky carry seen on issued sel=1 words
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PAW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [PAW-1:0]  prog_addr,
    input  logic [CW_W-1:0] prog_word,
    input  logic [PAW:0]    len,
    input  logic            start,
    input  logic            hold,
    input  logic            abort,
    reg_alu_seq_if.master   alu,
    output logic            busy,
    output logic            done,
    output logic [PAW:0]    pc,
    output logic            carry_flag
);

    localparam logic [PAW:0] DEPTH_L = (PAW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [PAW:0]    pc_q, pc_d;
    logic [PAW:0]    len_q, len_d;
    logic [CW_W-1:0] cw_q, cw_d;
    logic            done_q, done_d;
    logic            carry_q, carry_d;
    logic [CW_W-1:0] rd_word;
    logic [PAW:0]    eff_len;

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .PAW   (PAW)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && state_q == S_IDLE),
        .waddr (prog_addr),
        .wdata (prog_word),
        .raddr (pc_q[PAW-1:0]),
        .rdata (rd_word)
    );

    assign eff_len = (len > DEPTH_L) ? DEPTH_L : len;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cw_d    = '0;
        done_d  = 1'b0;
        // carry is judged on the word currently presented to reg_alu
        carry_d = carry_q | (cw_q[SEL_B] & alu.cout);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = eff_len;
                    pc_d    = '0;
                    carry_d = 1'b0;
                    state_d = (eff_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end else if (!hold) begin
                    cw_d    = rd_word;
                    pc_d    = pc_q + (PAW+1)'(1);
                    state_d = (pc_d == len_q) ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                pc_d    = abort ? '0 : pc_q;
                done_d  = !abort;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cw_q    <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cw_q    <= cw_d;
            done_q  <= done_d;
            carry_q <= carry_d;
        end
    end

    assign alu.sel       = cw_q[SEL_B];
    assign alu.wr        = cw_q[WR_B];
    assign alu.op        = cw_q[OP_MSB:OP_LSB];
    assign alu.rd_addr_a = cw_q[RDA_MSB:RDA_LSB];
    assign alu.rd_addr_b = cw_q[RDB_MSB:RDB_LSB];
    assign alu.wr_addr   = cw_q[WRA_MSB:WRA_LSB];
    assign alu.d_in      = cw_q[DIN_MSB:DIN_LSB];

    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign pc         = pc_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed self-checking bench for reg_alu_seq
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [28:0] prog_word = '0;
    logic [3:0]  len = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic        carry_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_alu_seq_if alu();

    reg_alu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_word  (prog_word),
        .len        (len),
        .start      (start),
        .hold       (hold),
        .abort      (abort),
        .alu        (alu),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .carry_flag (carry_flag)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [28:0] wd;
        logic        st;
        logic [3:0]  ln;
        logic        hd;
        logic        e_wr;
        logic [2:0]  e_wa;
        logic [15:0] e_din;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_pc;
    } vec_t;

    vec_t tv[18];

    function automatic logic [28:0] cw(logic s, logic w, logic [1:0] o, logic [2:0] ra,
                                       logic [2:0] rb, logic [2:0] wa, logic [15:0] d);
        return {s, w, o, ra, rb, wa, d};
    endfunction

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [28:0] wd, logic st,
                                logic [3:0] ln, logic hd, logic e_wr, logic [2:0] e_wa,
                                logic [15:0] e_din, logic e_busy, logic e_done, logic [3:0] e_pc);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.ln = ln; v.hd = hd;
        v.e_wr = e_wr; v.e_wa = e_wa; v.e_din = e_din;
        v.e_busy = e_busy; v.e_done = e_done; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(logic [2:0] a, logic [28:0] w);
        prog_we = 1'b1; prog_addr = a; prog_word = w;
        tick();
        prog_we = 1'b0;
    endtask

    logic [28:0] w0, w1, w2, w3, wx, wc;

    initial begin
        alu.cout = 1'b0;
        w0 = cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd3, 16'hcdef);
        w1 = cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd7, 16'h3210);
        w2 = cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd5, 16'h5555);
        w3 = cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 16'h1111);
        wx = cw(1'b1, 1'b1, 2'd3, 3'd7, 3'd7, 3'd6, 16'hdead);
        wc = cw(1'b1, 1'b1, 2'd0, 3'd1, 3'd5, 3'd2, 16'h0000);

        // load-and-run, hold bubbles, ignored start/prog_we while busy, start+prog_we together
        tv[0]  = mk(1, 0, w0, 0, 0, 0,  0, 0, 16'h0,    0, 0, 0);
        tv[1]  = mk(1, 1, w1, 0, 0, 0,  0, 0, 16'h0,    0, 0, 0);
        tv[2]  = mk(0, 0, 0,  1, 2, 0,  0, 0, 16'h0,    1, 0, 0);
        tv[3]  = mk(0, 0, 0,  0, 0, 0,  1, 3, 16'hcdef, 1, 0, 1);
        tv[4]  = mk(0, 0, 0,  0, 0, 0,  1, 7, 16'h3210, 1, 0, 2);
        tv[5]  = mk(0, 0, 0,  0, 0, 0,  0, 0, 16'h0,    0, 1, 2);
        tv[6]  = mk(0, 0, 0,  0, 0, 0,  0, 0, 16'h0,    0, 0, 2);
        tv[7]  = mk(1, 2, w2, 0, 0, 0,  0, 0, 16'h0,    0, 0, 2);
        tv[8]  = mk(0, 0, 0,  1, 3, 0,  0, 0, 16'h0,    1, 0, 0);
        tv[9]  = mk(0, 0, 0,  0, 0, 0,  1, 3, 16'hcdef, 1, 0, 1);
        tv[10] = mk(0, 0, 0,  0, 0, 1,  0, 0, 16'h0,    1, 0, 1);
        tv[11] = mk(0, 0, 0,  0, 0, 1,  0, 0, 16'h0,    1, 0, 1);
        tv[12] = mk(1, 2, wx, 1, 1, 0,  1, 7, 16'h3210, 1, 0, 2);
        tv[13] = mk(0, 0, 0,  0, 0, 0,  1, 5, 16'h5555, 1, 0, 3);
        tv[14] = mk(0, 0, 0,  0, 0, 0,  0, 0, 16'h0,    0, 1, 3);
        tv[15] = mk(1, 0, w3, 1, 1, 0,  0, 0, 16'h0,    1, 0, 0);
        tv[16] = mk(0, 0, 0,  0, 0, 0,  1, 1, 16'h1111, 1, 0, 1);
        tv[17] = mk(0, 0, 0,  0, 0, 0,  0, 0, 16'h0,    0, 1, 1);

        // reset state
        tick();
        tick();
        chk("rst_wr", 32'(alu.wr), 0);
        chk("rst_sel", 32'(alu.sel), 0);
        chk("rst_din", 32'(alu.d_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_carry", 32'(carry_flag), 0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            prog_we = tv[i].we; prog_addr = tv[i].wa; prog_word = tv[i].wd;
            start = tv[i].st; len = tv[i].ln; hold = tv[i].hd;
            tick();
            chk($sformatf("v%0d_wr", i), 32'(alu.wr), 32'(tv[i].e_wr));
            chk($sformatf("v%0d_wa", i), 32'(alu.wr_addr), 32'(tv[i].e_wa));
            chk($sformatf("v%0d_din", i), 32'(alu.d_in), 32'(tv[i].e_din));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].e_done));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tv[i].e_pc));
        end
        prog_we = 0; start = 0; hold = 0;

        // abort during word 1 of len=4 (hold raised together: abort wins)
        ld(3, cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd4, 16'h4444));
        start = 1; len = 4;
        tick();
        start = 0;
        chk("ab_busy", 32'(busy), 1);
        tick();
        chk("ab_w0", 32'(alu.wr_addr), 1);
        tick();
        chk("ab_w1", 32'(alu.d_in), 32'h3210);
        chk("ab_pc2", 32'(pc), 2);
        abort = 1; hold = 1;
        tick();
        abort = 0; hold = 0;
        chk("ab_wr", 32'(alu.wr), 0);
        chk("ab_din", 32'(alu.d_in), 0);
        chk("ab_idle", 32'(busy), 0);
        chk("ab_pc", 32'(pc), 0);
        chk("ab_done", 32'(done), 0);
        tick();
        chk("ab_nodone", 32'(done), 0);
        start = 1; len = 1;
        tick();
        start = 0;
        tick();
        chk("ab_rerun_wr", 32'(alu.wr), 1);
        chk("ab_rerun_din", 32'(alu.d_in), 32'h1111);
        tick();
        chk("ab_rerun_done", 32'(done), 1);

        // len=0: straight to DRAIN, done after two edges, no write
        start = 1; len = 0;
        tick();
        start = 0;
        chk("l0_busy", 32'(busy), 1);
        chk("l0_wr", 32'(alu.wr), 0);
        chk("l0_done0", 32'(done), 0);
        tick();
        chk("l0_done", 32'(done), 1);
        chk("l0_idle", 32'(busy), 0);
        chk("l0_wr2", 32'(alu.wr), 0);

        // len=9 clamps to 8 words; cout high on sel=0 words must not set carry
        for (int a = 4; a < 8; a++)
            ld(3'(a), cw(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'(a), 16'(a * 'h1111)));
        alu.cout = 1;
        start = 1; len = 9;
        tick();
        start = 0;
        begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            while (!done && cyc < 40) begin
                tick();
                cyc++;
                if (alu.wr === 1'b1) n++;
            end
            chk("l9_done_seen", 32'(done), 1);
            chk("l9_words", 32'(n), 8);
            chk("l9_pc", 32'(pc), 8);
            chk("l9_carry", 32'(carry_flag), 0);
        end

        // carry: sel=1 word with cout=1 sets sticky flag
        alu.cout = 0;
        ld(0, wc);
        alu.cout = 1;
        start = 1; len = 1;
        tick();
        start = 0;
        chk("cy_pre", 32'(carry_flag), 0);
        tick();
        chk("cy_sel", 32'(alu.sel), 1);
        chk("cy_fields", 32'({alu.op, alu.rd_addr_a, alu.rd_addr_b, alu.wr_addr}),
            32'({2'd0, 3'd1, 3'd5, 3'd2}));
        chk("cy_not_yet", 32'(carry_flag), 0);
        tick();
        chk("cy_set", 32'(carry_flag), 1);
        chk("cy_done", 32'(done), 1);
        alu.cout = 0;
        tick();
        tick();
        chk("cy_held", 32'(carry_flag), 1);
        start = 1; len = 2;
        tick();
        start = 0;
        chk("cy_clr_start", 32'(carry_flag), 0);
        alu.cout = 1;
        tick();
        chk("cy_run_sel", 32'(alu.sel), 1);

        // reset two cycles mid-run
        reset = 1;
        tick();
        chk("mr_wr", 32'(alu.wr), 0);
        chk("mr_sel", 32'(alu.sel), 0);
        chk("mr_din", 32'(alu.d_in), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_pc", 32'(pc), 0);
        chk("mr_carry", 32'(carry_flag), 0);
        tick();
        chk("mr2_busy", 32'(busy), 0);
        chk("mr2_done", 32'(done), 0);
        reset = 0;
        tick();
        chk("mr_after_busy", 32'(busy), 0);
        chk("mr_after_wr", 32'(alu.wr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
